// File: rtl/alu_issue_ctrl.sv
// Operand/sequencing stage for the external 16-bit 4-function ALU: owns an
// 8x16 register file, issues reg-to-reg commands and writes results back.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_rd,
    input  logic [2:0]  cmd_rs1,
    input  logic [2:0]  cmd_rs2,
    input  logic        ld_en,
    input  logic [2:0]  ld_addr,
    input  logic [15:0] ld_data,
    output logic [1:0]  alu_op,
    output logic [15:0] alu_i0,
    output logic [15:0] alu_i1,
    input  logic [15:0] alu_o,
    input  logic        alu_cout,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_cout,
    output logic        rsp_zero,
    output logic        busy
);

    // state | meaning
    // IDLE  | ready for a command; operands latched on accept
    // ISSUE | ALU inputs stable; result and carry sampled at closing edge
    // WRITE | response valid; result written to rd at closing edge

    localparam int NREG = 8;
    localparam int W    = 16;
    localparam int AW   = $clog2(NREG);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  regs [NREG];
    logic [AW-1:0] rd_q;
    logic [W-1:0]  res_q;
    logic          cout_q;
    logic          zero_q;
    logic          accept;
    logic [W-1:0]  rs1_val;
    logic [W-1:0]  rs2_val;

    // r0 is hardwired to zero regardless of array contents
    assign rs1_val = (cmd_rs1 == '0) ? '0 : regs[cmd_rs1];
    assign rs2_val = (cmd_rs2 == '0) ? '0 : regs[cmd_rs2];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = reset;
                busy      = 1'b0;
                accept    = cmd_valid;
                state_nxt = cmd_valid ? ISSUE : IDLE;
            end
            ISSUE: begin
                state_nxt = WRITE;
            end
            WRITE: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            alu_op <= '0;
            alu_i0 <= '0;
            alu_i1 <= '0;
            rd_q   <= '0;
            res_q  <= '0;
            cout_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            if (accept) begin
                alu_op <= cmd_op;
                alu_i0 <= rs1_val;
                alu_i1 <= rs2_val;
                rd_q   <= cmd_rd;
            end
            if (state == ISSUE) begin
                res_q  <= alu_o;
                cout_q <= ~alu_op[1] & alu_cout;
                zero_q <= (alu_o == '0);
            end
            if (ld_en && ld_addr != '0) begin
                regs[ld_addr] <= ld_data;
            end
            // placed after the load so a same-edge load to rd loses
            if (state == WRITE && rd_q != '0) begin
                regs[rd_q] <= res_q;
            end
        end
    end

    assign rsp_data = res_q;
    assign rsp_cout = cout_q;
    assign rsp_zero = zero_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus randomized
// commands/loads against an architectural register-file model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_rd;
    logic [2:0]  cmd_rs1;
    logic [2:0]  cmd_rs2;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [1:0]  alu_op;
    logic [15:0] alu_i0;
    logic [15:0] alu_i1;
    logic [15:0] alu_o;
    logic        alu_cout;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_cout;
    logic        rsp_zero;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;
    int n_pulse = 0;
    logic [15:0] mreg [8];

    alu_issue_ctrl dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_op(alu_op), .alu_i0(alu_i0), .alu_i1(alu_i1),
        .alu_o(alu_o), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_cout(rsp_cout),
        .rsp_zero(rsp_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    // External ALU; and/or drive cout high so the block's masking is visible
    always_comb begin
        case (alu_op)
            2'b00:   {alu_cout, alu_o} = {1'b0, alu_i0} + {1'b0, alu_i1};
            2'b01:   {alu_cout, alu_o} = {1'b0, alu_i0} + {1'b0, ~alu_i1} + 17'd1;
            2'b10:   {alu_cout, alu_o} = {1'b1, alu_i0 & alu_i1};
            default: {alu_cout, alu_o} = {1'b1, alu_i0 | alu_i1};
        endcase
    end

    always @(posedge clk) if (rsp_valid === 1'b1) n_pulse++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [16:0] alu_ref(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {(a >= b), 16'(a - b)};
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
        if (a != 3'd0) mreg[a] = d;
    endtask

    // ld_mode: 0 none, 1 load on the accept edge, 2 load during WRITE
    task automatic do_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, input bit hold, input int ld_mode,
                          input logic [2:0] la, input logic [15:0] ld_d);
        logic [15:0] a, b;
        logic [16:0] r;
        a = mreg[rs1];
        b = mreg[rs2];
        r = alu_ref(op, a, b);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        check_eq("ready_idle", cmd_ready, 1);
        if (ld_mode == 1) begin
            ld_en = 1'b1; ld_addr = la; ld_data = ld_d;
        end
        tick();
        ld_en = 1'b0;
        if (ld_mode == 1 && la != 3'd0) mreg[la] = ld_d;
        if (hold) begin
            cmd_op = 2'($urandom); cmd_rd = 3'($urandom);
            cmd_rs1 = 3'($urandom); cmd_rs2 = 3'($urandom);
        end else begin
            cmd_valid = 1'b0;
        end
        check_eq("ready_issue", cmd_ready, 0);
        check_eq("busy_issue", busy, 1);
        check_eq("rsp_valid_issue", rsp_valid, 0);
        check_eq("alu_op", alu_op, op);
        check_eq("alu_i0", alu_i0, a);
        check_eq("alu_i1", alu_i1, b);
        if (ld_mode == 2) begin
            ld_en = 1'b1; ld_addr = la; ld_data = ld_d;
        end
        tick();
        ld_en = 1'b0;
        check_eq("rsp_valid_write", rsp_valid, 1);
        check_eq("ready_write", cmd_ready, 0);
        check_eq("rsp_data", rsp_data, r[15:0]);
        check_eq("rsp_cout", rsp_cout, r[16]);
        check_eq("rsp_zero", rsp_zero, (r[15:0] == 16'h0));
        tick();
        if (rd != 3'd0) mreg[rd] = r[15:0];
        if (ld_mode == 2 && la != 3'd0 && la != rd) mreg[la] = ld_d;
        check_eq("rsp_valid_after", rsp_valid, 0);
        check_eq("ready_after", cmd_ready, 1);
        check_eq("busy_after", busy, 0);
        check_eq("rsp_data_hold", rsp_data, r[15:0]);
    endtask

    task automatic cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
        do_cmd(op, rd, rs1, rs2, 1'b0, 0, 3'd0, 16'h0);
    endtask

    // Read a register through an OR with r0 into r0
    task automatic read_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
        cmd(2'b11, 3'd0, a, 3'd0);
        check_eq(tag, rsp_data, exp);
    endtask

    initial begin
        int p0;
        for (int i = 0; i < 8; i++) mreg[i] = 16'h0;
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        tick(); tick();
        check_eq("rst_ready", cmd_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_rsp_cout", rsp_cout, 0);
        check_eq("rst_rsp_zero", rsp_zero, 0);
        check_eq("rst_alu_op", alu_op, 0);
        check_eq("rst_alu_i0", alu_i0, 0);
        check_eq("rst_alu_i1", alu_i1, 0);
        reset = 1'b1;
        #1;
        check_eq("rel_ready", cmd_ready, 1);
        tick();

        // basic add and readback
        load(3'd1, 16'h0005);
        load(3'd2, 16'h0003);
        cmd(2'b00, 3'd3, 3'd1, 3'd2);
        check_eq("add_5_3", rsp_data, 16'h0008);
        read_reg("r3_after_add", 3'd3, 16'h0008);

        // subtraction, borrow and zero cases
        cmd(2'b01, 3'd6, 3'd2, 3'd1);
        check_eq("sub_neg", rsp_data, 16'hFFFE);
        check_eq("sub_neg_cout", rsp_cout, 0);
        cmd(2'b01, 3'd6, 3'd1, 3'd1);
        check_eq("sub_self_zero", rsp_zero, 1);
        check_eq("sub_self_cout", rsp_cout, 1);

        // wrap and logic ops
        load(3'd4, 16'hFFFF);
        load(3'd5, 16'h0001);
        cmd(2'b00, 3'd7, 3'd4, 3'd5);
        check_eq("add_wrap_cout", rsp_cout, 1);
        load(3'd4, 16'hF0F0);
        load(3'd5, 16'h0FF0);
        cmd(2'b10, 3'd7, 3'd4, 3'd5);
        check_eq("and_val", rsp_data, 16'h00F0);
        cmd(2'b11, 3'd7, 3'd4, 3'd5);
        check_eq("or_val", rsp_data, 16'hFFF0);
        check_eq("or_cout", rsp_cout, 0);

        // dependent stream with cmd_valid held high
        p0 = n_pulse;
        do_cmd(2'b00, 3'd3, 3'd1, 3'd2, 1'b1, 0, 3'd0, 16'h0);
        do_cmd(2'b00, 3'd3, 3'd3, 3'd1, 1'b1, 0, 3'd0, 16'h0);
        do_cmd(2'b00, 3'd6, 3'd3, 3'd3, 1'b0, 0, 3'd0, 16'h0);
        check_eq("stream_pulses", n_pulse - p0, 3);
        read_reg("r6_stream", 3'd6, 16'h001A);

        // r0 protection and load collisions
        cmd(2'b00, 3'd0, 3'd1, 3'd2);
        check_eq("rd0_reported", rsp_data, 16'h0008);
        read_reg("r0_after_cmd", 3'd0, 16'h0000);
        load(3'd0, 16'h1234);
        read_reg("r0_after_load", 3'd0, 16'h0000);
        do_cmd(2'b00, 3'd7, 3'd1, 3'd2, 1'b0, 2, 3'd7, 16'hBEEF);
        read_reg("r7_wb_wins", 3'd7, 16'h0008);
        do_cmd(2'b11, 3'd0, 3'd1, 3'd1, 1'b0, 1, 3'd1, 16'h00AA);
        read_reg("r1_after_accept_load", 3'd1, 16'h00AA);

        // reset during ISSUE drops the command
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_rd = 3'd3; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2;
        tick();
        cmd_valid = 1'b0;
        reset = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) mreg[i] = 16'h0;
        check_eq("midrst_ready", cmd_ready, 0);
        check_eq("midrst_rsp_valid", rsp_valid, 0);
        check_eq("midrst_rsp_data", rsp_data, 0);
        reset = 1'b1;
        #1;
        check_eq("midrst_rel_ready", cmd_ready, 1);
        check_eq("midrst_busy", busy, 0);
        tick();
        check_eq("midrst_no_rsp", rsp_valid, 0);
        cmd(2'b00, 3'd3, 3'd1, 3'd2);
        check_eq("post_rst_zero", rsp_zero, 1);
        read_reg("r5_cleared", 3'd5, 16'h0000);

        // randomized loads and commands
        for (int k = 0; k < 120; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                load(3'($urandom), 16'($urandom));
            end else begin
                do_cmd(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'b0,
                       int'($urandom_range(0, 2)), 3'($urandom), 16'($urandom));
            end
        end
        for (int i = 1; i < 8; i++) read_reg("final_reg", 3'(i), mreg[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
